// File: rtl/fetch_sequencer.sv
// Fetch-PC sequencer: owns the fetch address and arbitrates
// commit correction, JAL redirect, prediction and PC+4.
module fetch_sequencer #(
  parameter int unsigned      WIDTH    = 31,
  parameter logic [WIDTH:0]   RESET_PC = '0,
  parameter int unsigned      BUBBLE   = 2
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             mispredict,
  input  logic             misdirect,
  input  logic [WIDTH:0]   resolvedTarget,
  input  logic             jalValid,
  input  logic [WIDTH:0]   jalTarget,
  input  logic             predictorHit,
  input  logic [WIDTH:0]   predictedPC,
  input  logic             stall,
  output logic [WIDTH:0]   nextPC,
  output logic             fetchValid,
  output logic             freeze,
  output logic             kill,
  output logic [15:0]      redirectCount
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HOLD
  } state_t;

  localparam logic [WIDTH:0] PC_STEP = (WIDTH+1)'(4);
  localparam logic [1:0]     BUB     = 2'(BUBBLE);

  state_t         state;
  logic [1:0]     bub;
  logic           pend;
  logic [WIDTH:0] pend_pc;

  logic           commit;
  logic           redir;
  logic [WIDTH:0] redir_pc;
  logic [WIDTH:0] adv_pc;
  logic [15:0]    cnt_inc;

  assign commit  = mispredict | misdirect;
  assign cnt_inc = (redirectCount == 16'hFFFF) ?
                   redirectCount : redirectCount + 16'd1;

  // Pick the redirect source for this cycle and the RUN advance target.
  always_comb begin
    redir    = 1'b0;
    redir_pc = resolvedTarget;
    adv_pc   = predictorHit ? predictedPC : nextPC + PC_STEP;
    unique case (state)
      RUN, FLUSH: begin
        if (commit) begin
          redir    = 1'b1;
          redir_pc = resolvedTarget;
        end else if (jalValid) begin
          redir    = 1'b1;
          redir_pc = jalTarget;
        end
      end
      HOLD: begin
        if (commit) begin
          redir    = 1'b1;
          redir_pc = resolvedTarget;
        end else if (!stall && jalValid) begin
          redir    = 1'b1;
          redir_pc = jalTarget;
        end else if (!stall && pend) begin
          redir    = 1'b1;
          redir_pc = pend_pc;
        end
      end
      default: begin
        redir = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered fetch controls.
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      state         <= BOOT;
      nextPC        <= RESET_PC;
      fetchValid    <= 1'b0;
      freeze        <= 1'b0;
      kill          <= 1'b0;
      redirectCount <= 16'd0;
      bub           <= 2'd0;
      pend          <= 1'b0;
      pend_pc       <= '0;
    end else begin
      kill <= 1'b0;
      if (redir) begin
        state         <= FLUSH;
        nextPC        <= redir_pc;
        kill          <= 1'b1;
        fetchValid    <= 1'b0;
        freeze        <= 1'b0;
        bub           <= BUB;
        pend          <= 1'b0;
        redirectCount <= cnt_inc;
      end else begin
        unique case (state)
          BOOT: begin
            state      <= RUN;
            nextPC     <= RESET_PC;
            fetchValid <= 1'b1;
          end
          RUN: begin
            if (stall) begin
              state  <= HOLD;
              freeze <= 1'b1;
            end else begin
              nextPC <= adv_pc;
            end
          end
          FLUSH: begin
            bub <= bub - 2'd1;
            if (bub <= 2'd1) begin
              state      <= RUN;
              fetchValid <= 1'b1;
            end
          end
          HOLD: begin
            if (stall) begin
              if (jalValid) begin
                pend    <= 1'b1;
                pend_pc <= jalTarget;
              end
            end else begin
              state  <= RUN;
              freeze <= 1'b0;
              nextPC <= adv_pc;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed vectors,
// expected outputs queued per cycle and checked by a monitor.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        globalReset;
  logic        mispredict, misdirect;
  logic [31:0] resolvedTarget;
  logic        jalValid;
  logic [31:0] jalTarget;
  logic        predictorHit;
  logic [31:0] predictedPC;
  logic        stall;
  logic [31:0] nextPC;
  logic        fetchValid, freeze, kill;
  logic [15:0] redirectCount;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        fv;
    logic        fz;
    logic        kl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer #(
    .WIDTH(31),
    .RESET_PC(32'h0),
    .BUBBLE(2)
  ) dut (
    .clk(clk),
    .globalReset(globalReset),
    .mispredict(mispredict),
    .misdirect(misdirect),
    .resolvedTarget(resolvedTarget),
    .jalValid(jalValid),
    .jalTarget(jalTarget),
    .predictorHit(predictorHit),
    .predictedPC(predictedPC),
    .stall(stall),
    .nextPC(nextPC),
    .fetchValid(fetchValid),
    .freeze(freeze),
    .kill(kill),
    .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare queued expectations once their cycle arrives.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      checks++;
      if (m.cyc != cyc || nextPC !== m.pc || fetchValid !== m.fv ||
          freeze !== m.fz || kill !== m.kl ||
          redirectCount !== m.cnt) begin
        errors++;
        $display("FAIL cyc%0d got pc=%h fv=%b fz=%b kill=%b cnt=%0d want pc=%h fv=%b fz=%b kill=%b cnt=%0d",
                 m.cyc, nextPC, fetchValid, freeze, kill, redirectCount,
                 m.pc, m.fv, m.fz, m.kl, m.cnt);
      end
    end
  end

  task automatic idle();
    mispredict   = 1'b0;
    misdirect    = 1'b0;
    jalValid     = 1'b0;
    predictorHit = 1'b0;
    stall        = 1'b0;
  endtask

  // Queue the outputs expected after the coming edge, then take it.
  task automatic tick(input logic [31:0] pc, input logic fv,
                      input logic fz, input logic kl,
                      input logic [15:0] cnt);
    exp_t e;
    e.cyc = cyc + 1;
    e.pc  = pc;
    e.fv  = fv;
    e.fz  = fz;
    e.kl  = kl;
    e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if (nextPC !== 32'h0 || fetchValid !== 1'b0 || freeze !== 1'b0 ||
        kill !== 1'b0 || redirectCount !== 16'd0) begin
      errors++;
      $display("FAIL %s got pc=%h fv=%b fz=%b kill=%b cnt=%0d want all zero",
               name, nextPC, fetchValid, freeze, kill, redirectCount);
    end
  endtask

  initial begin
    idle();
    resolvedTarget = '0;
    jalTarget      = '0;
    predictedPC    = '0;
    globalReset    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    globalReset = 1'b1;

    // BOOT -> RUN and sequential advance
    tick(32'h0,  1, 0, 0, 0);
    tick(32'h4,  1, 0, 0, 0);
    tick(32'h8,  1, 0, 0, 0);
    tick(32'hC,  1, 0, 0, 0);
    tick(32'h10, 1, 0, 0, 0);

    // prediction, zero bubble
    predictorHit = 1; predictedPC = 32'h80;
    tick(32'h80, 1, 0, 0, 0);
    tick(32'h84, 1, 0, 0, 0);

    // mispredict with two bubbles
    mispredict = 1; resolvedTarget = 32'h200;
    tick(32'h200, 0, 0, 1, 1);
    tick(32'h200, 0, 0, 0, 1);
    tick(32'h200, 1, 0, 0, 1);
    tick(32'h204, 1, 0, 0, 1);

    // commit and JAL together; prediction ignored in FLUSH
    mispredict = 1; resolvedTarget = 32'h300;
    jalValid = 1; jalTarget = 32'h500;
    tick(32'h300, 0, 0, 1, 2);
    predictorHit = 1; predictedPC = 32'h999;
    tick(32'h300, 0, 0, 0, 2);
    tick(32'h300, 1, 0, 0, 2);
    tick(32'h304, 1, 0, 0, 2);

    // JAL, then a second JAL restarting the flush
    jalValid = 1; jalTarget = 32'h400;
    tick(32'h400, 0, 0, 1, 3);
    jalValid = 1; jalTarget = 32'h440;
    tick(32'h440, 0, 0, 1, 4);
    tick(32'h440, 0, 0, 0, 4);
    tick(32'h440, 1, 0, 0, 4);
    tick(32'h444, 1, 0, 0, 4);

    // four-cycle stall with a JAL latched as pending
    stall = 1;
    tick(32'h444, 1, 1, 0, 4);
    stall = 1; jalValid = 1; jalTarget = 32'h600;
    tick(32'h444, 1, 1, 0, 4);
    stall = 1;
    tick(32'h444, 1, 1, 0, 4);
    stall = 1;
    tick(32'h444, 1, 1, 0, 4);
    tick(32'h600, 0, 0, 1, 5);
    tick(32'h600, 0, 0, 0, 5);
    tick(32'h600, 1, 0, 0, 5);
    tick(32'h604, 1, 0, 0, 5);

    // commit overrides a stall and drops the pending JAL
    stall = 1;
    tick(32'h604, 1, 1, 0, 5);
    stall = 1; jalValid = 1; jalTarget = 32'h700;
    tick(32'h604, 1, 1, 0, 5);
    stall = 1; misdirect = 1; resolvedTarget = 32'h800;
    tick(32'h800, 0, 0, 1, 6);
    tick(32'h800, 0, 0, 0, 6);
    tick(32'h800, 1, 0, 0, 6);
    stall = 1;
    tick(32'h800, 1, 1, 0, 6);
    tick(32'h804, 1, 0, 0, 6);
    tick(32'h808, 1, 0, 0, 6);

    // wrap at the top of the address space
    mispredict = 1; resolvedTarget = 32'hFFFF_FFF8;
    tick(32'hFFFF_FFF8, 0, 0, 1, 7);
    tick(32'hFFFF_FFF8, 0, 0, 0, 7);
    tick(32'hFFFF_FFF8, 1, 0, 0, 7);
    tick(32'hFFFF_FFFC, 1, 0, 0, 7);
    tick(32'h0,         1, 0, 0, 7);

    // asynchronous reset in the middle of a flush
    jalValid = 1; jalTarget = 32'h900;
    tick(32'h900, 0, 0, 1, 8);
    @(negedge clk);
    #2;
    globalReset = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    globalReset = 1'b1;
    tick(32'h0, 1, 0, 0, 0);
    tick(32'h4, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
